// File: rtl/unpack.sv
// unpack: scatters an in-order stream of packed W-bit lanes into N-lane output
// beats. Each mask selects the destination lanes of one output beat. The k-th
// oldest buffered entry goes to the k-th lowest set bit of the mask.
// Optional feature: define UNPACK_FLUSH_EN to add a 'flush' input. Flush
// discards residue and leaves the output register untouched.
module unpack #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef UNPACK_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*W-1:0]         in_w,
  input  logic [$clog2(N):0]     in_cnt,
  input  logic                   msk_valid,
  output logic                   msk_ready,
  input  logic [N-1:0]           msk,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*W-1:0]         out_w,
  output logic [N-1:0]           out_vld
);

  localparam int unsigned D  = 2 * N;
  localparam int unsigned LW = $clog2(N);
  localparam int unsigned AW = $clog2(D);
  localparam int unsigned OW = AW + 1;

  logic [W-1:0]   res_q  [D];
  logic [W-1:0]   res_nx [D];
  logic [W-1:0]   in_lane [N];
  logic [OW-1:0]  occ;
  logic [OW-1:0]  occ_nx;
  logic [OW-1:0]  pop;
  logic [OW-1:0]  pop_use;
  logic [OW-1:0]  rem;
  logic [N*W-1:0] out_w_nx;
  logic           in_acc;
  logic           msk_acc;
  logic           flush_c;

`ifdef UNPACK_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // Handshakes depend only on registered occupancy and output state
  assign in_ready  = (occ <= OW'(N)) & ~flush_c;
  assign msk_ready = (occ >= pop) & (~out_valid | out_ready) & ~flush_c;
  assign in_acc    = in_valid & in_ready;
  assign msk_acc   = msk_valid & msk_ready;

  assign pop_use = msk_acc ? pop : '0;
  assign rem     = occ - pop_use;
  assign occ_nx  = rem + (in_acc ? OW'(in_cnt) : '0);

  // Split the packed input beat into lanes
  always_comb begin
    for (int j = 0; j < N; j++) begin
      in_lane[j] = in_w[j*W +: W];
    end
  end

  // Number of buffer entries the presented mask would consume
  always_comb begin
    pop = '0;
    for (int j = 0; j < N; j++) begin
      pop = pop + OW'(msk[j]);
    end
  end

  // Scatter the oldest entries into the set lanes of the mask, zero elsewhere
  always_comb begin
    logic [AW-1:0] k;
    out_w_nx = '0;
    k        = '0;
    for (int j = 0; j < N; j++) begin
      if (msk[j]) begin
        out_w_nx[j*W +: W] = res_q[k];
        k = k + AW'(1);
      end
    end
  end

  // Drop consumed entries from the head, then append accepted input lanes
  always_comb begin
    int src;
    int idx;
    for (int i = 0; i < D; i++) begin
      src = i + int'(pop_use);
      if (src < int'(D)) begin
        res_nx[i] = res_q[AW'(src)];
      end else begin
        res_nx[i] = res_q[i];
      end
      idx = i - int'(rem);
      if (in_acc && (idx >= 0) && (idx < int'(in_cnt))) begin
        res_nx[i] = in_lane[LW'(idx)];
      end
    end
  end

  // Control state: occupancy and output valids, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= '0;
      out_valid <= 1'b0;
      out_vld   <= '0;
    end else begin
      occ <= flush_c ? '0 : occ_nx;
      if (msk_acc) begin
        out_valid <= 1'b1;
        out_vld   <= msk;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Datapath registers, intentionally not reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < D; i++) begin
        res_q[i] <= res_nx[i];
      end
      if (msk_acc) begin
        out_w <= out_w_nx;
      end
    end
  end

`ifndef SYNTHESIS
  // Lane counts above N are illegal
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      assert (in_cnt <= ($clog2(N)+1)'(N))
        else $error("unpack: in_cnt %0d exceeds N", in_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_unpack.sv
// tb_unpack: randomized and directed checks of unpack against a queue model.
module tb_unpack;
  localparam int N = 8;
  localparam int W = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [N*W-1:0]     in_w;
  logic [$clog2(N):0] in_cnt;
  logic               msk_valid;
  logic               msk_ready;
  logic [N-1:0]       msk;
  logic               out_valid;
  logic               out_ready;
  logic [N*W-1:0]     out_w;
  logic [N-1:0]       out_vld;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO of words plus expected output register
  logic [W-1:0]   q[$];
  bit             m_ov;
  logic [N-1:0]   m_vld;
  logic [N*W-1:0] m_w;

  unpack #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_w      (in_w),
    .in_cnt    (in_cnt),
    .msk_valid (msk_valid),
    .msk_ready (msk_ready),
    .msk       (msk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_w     (out_w),
    .out_vld   (out_vld)
  );

  always #5 clk = ~clk;

  function automatic bit exp_in_rdy();
    return q.size() <= N;
  endfunction

  function automatic bit exp_msk_rdy();
    return (q.size() >= $countones(msk)) && (!m_ov || out_ready);
  endfunction

  function automatic logic [N*W-1:0] rand_beat();
    logic [N*W-1:0] b;
    for (int j = 0; j < N; j++) b[j*W +: W] = $urandom;
    return b;
  endfunction

  // One clock: decide handshakes from the model, clock, update the model
  task automatic advance();
    bit ia, ma, s_rst, s_ordy;
    logic [N-1:0] s_msk;
    logic [N*W-1:0] s_w;
    int s_cnt;
    ia = in_valid && exp_in_rdy();
    ma = msk_valid && exp_msk_rdy();
    s_rst = rst; s_ordy = out_ready; s_msk = msk; s_w = in_w; s_cnt = int'(in_cnt);
    @(posedge clk);
    if (s_rst) begin
      q.delete();
      m_ov = 1'b0;
      m_vld = '0;
    end else begin
      if (ma) begin
        m_w = '0;
        for (int j = 0; j < N; j++)
          if (s_msk[j]) m_w[j*W +: W] = q.pop_front();
        m_vld = s_msk;
        m_ov = 1'b1;
      end else if (s_ordy) begin
        m_ov = 1'b0;
      end
      if (ia)
        for (int i = 0; i < s_cnt; i++) q.push_back(s_w[i*W +: W]);
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_cnt = '0; in_w = '0;
    msk_valid = 1'b0; msk = '0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    in_valid = 1'b1; in_cnt = 4'd3; in_w = rand_beat();
    msk_valid = 1'b1; msk = '0;
    advance();
    advance();
    rst = 1'b0;
    idle();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_vld !== '0) begin errors++; $display("FAIL rst_out_vld got %h want 00", out_vld); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (msk_ready !== 1'b1) begin errors++; $display("FAIL rst_msk_ready got %b want 1", msk_ready); end
    msk = 8'h01;
    #1;
    checks++; if (msk_ready !== 1'b0) begin errors++; $display("FAIL rst_no_accept got %b want 0", msk_ready); end
    idle();
  endtask

  task automatic test_example();
    logic [W-1:0] a, b, c;
    logic [N*W-1:0] exp_w;
    a = 32'hAAAA_0001; b = 32'hBBBB_0002; c = 32'hCCCC_0003;
    idle();
    in_valid = 1'b1; in_cnt = 4'd3; in_w = rand_beat();
    in_w[0 +: W] = a; in_w[W +: W] = b; in_w[2*W +: W] = c;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ex_in_ready got %b want 1", in_ready); end
    advance();
    in_valid = 1'b0;
    msk_valid = 1'b1; msk = 8'b1010_0100;
    #1;
    checks++; if (msk_ready !== 1'b1) begin errors++; $display("FAIL ex_msk_ready got %b want 1", msk_ready); end
    advance();
    msk_valid = 1'b0;
    exp_w = '0;
    exp_w[2*W +: W] = a; exp_w[5*W +: W] = b; exp_w[7*W +: W] = c;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ex_out_valid got %b want 1", out_valid); end
    checks++; if (out_vld !== 8'hA4) begin errors++; $display("FAIL ex_out_vld got %h want a4", out_vld); end
    checks++; if (out_w !== exp_w) begin errors++; $display("FAIL ex_out_w got %h want %h", out_w, exp_w); end
    msk = 8'h01;
    #1;
    checks++; if (msk_ready !== 1'b0) begin errors++; $display("FAIL ex_empty got %b want 0", msk_ready); end
    idle();
    advance();
  endtask

  task automatic test_wait_mask();
    logic [W-1:0] a, b, c;
    logic [N*W-1:0] exp_w;
    a = $urandom; b = $urandom; c = $urandom;
    idle();
    in_valid = 1'b1; in_cnt = 4'd2; in_w = rand_beat();
    in_w[0 +: W] = a; in_w[W +: W] = b;
    advance();
    in_valid = 1'b0;
    msk_valid = 1'b1; msk = 8'h07;
    #1;
    checks++; if (msk_ready !== 1'b0) begin errors++; $display("FAIL wait_short got %b want 0", msk_ready); end
    advance();
    in_valid = 1'b1; in_cnt = 4'd1; in_w = rand_beat(); in_w[0 +: W] = c;
    #1;
    checks++; if (msk_ready !== 1'b0) begin errors++; $display("FAIL wait_same_cycle got %b want 0", msk_ready); end
    advance();
    in_valid = 1'b0;
    #1;
    checks++; if (msk_ready !== 1'b1) begin errors++; $display("FAIL wait_ready got %b want 1", msk_ready); end
    advance();
    msk_valid = 1'b0;
    exp_w = '0;
    exp_w[0 +: W] = a; exp_w[W +: W] = b; exp_w[2*W +: W] = c;
    checks++; if (out_vld !== 8'h07) begin errors++; $display("FAIL wait_vld got %h want 07", out_vld); end
    checks++; if (out_w !== exp_w) begin errors++; $display("FAIL wait_w got %h want %h", out_w, exp_w); end
    idle();
    advance();
  endtask

  task automatic test_full_hold();
    idle();
    in_valid = 1'b1; in_cnt = 4'd8; in_w = rand_beat();
    advance();
    in_valid = 1'b0;
    msk_valid = 1'b1; msk = 8'h00;
    advance();
    out_ready = 1'b0; msk = 8'hFF;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_in_ready got %b want 1", in_ready); end
    checks++; if (msk_ready !== 1'b0) begin errors++; $display("FAIL hold_msk_ready got %b want 0", msk_ready); end
    advance();
    advance();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b want 1", out_valid); end
    checks++; if (out_vld !== 8'h00) begin errors++; $display("FAIL hold_vld got %h want 00", out_vld); end
    out_ready = 1'b1;
    #1;
    checks++; if (msk_ready !== 1'b1) begin errors++; $display("FAIL hold_release got %b want 1", msk_ready); end
    advance();
    msk_valid = 1'b0;
    checks++; if (out_vld !== 8'hFF) begin errors++; $display("FAIL hold_new_vld got %h want ff", out_vld); end
    checks++; if (out_w !== m_w) begin errors++; $display("FAIL hold_new_w got %h want %h", out_w, m_w); end
    msk = 8'h01;
    #1;
    checks++; if (msk_ready !== 1'b0) begin errors++; $display("FAIL hold_drained got %b want 0", msk_ready); end
    idle();
    advance();
  endtask

  task automatic test_overfill();
    idle();
    in_valid = 1'b1; in_cnt = 4'd8; in_w = rand_beat();
    advance();
    in_cnt = 4'd1; in_w = rand_beat();
    advance();
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL over_occ9 got %b want 0", in_ready); end
    msk_valid = 1'b1; msk = 8'h0F;
    advance();
    msk_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL over_occ5 got %b want 1", in_ready); end
    checks++; if (out_w !== m_w) begin errors++; $display("FAIL over_w4 got %h want %h", out_w, m_w); end
    in_valid = 1'b1; in_cnt = 4'd8; in_w = rand_beat();
    advance();
    in_valid = 1'b0;
    msk_valid = 1'b1; msk = 8'hFF;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL over_occ13 got %b want 0", in_ready); end
    advance();
    checks++; if (out_w !== m_w) begin errors++; $display("FAIL over_w8 got %h want %h", out_w, m_w); end
    msk = 8'h1F;
    advance();
    msk_valid = 1'b0;
    checks++; if (out_w !== m_w) begin errors++; $display("FAIL over_w5 got %h want %h", out_w, m_w); end
    msk = 8'h01;
    #1;
    checks++; if (msk_ready !== 1'b0) begin errors++; $display("FAIL over_empty got %b want 0", msk_ready); end
    idle();
    advance();
  endtask

  task automatic test_zero();
    idle();
    msk_valid = 1'b1; msk = 8'h00;
    #1;
    checks++; if (msk_ready !== 1'b1) begin errors++; $display("FAIL zero_msk_ready got %b want 1", msk_ready); end
    advance();
    msk_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got %b want 1", out_valid); end
    checks++; if (out_vld !== 8'h00) begin errors++; $display("FAIL zero_vld got %h want 00", out_vld); end
    in_valid = 1'b1; in_cnt = '0; in_w = rand_beat();
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_in_ready got %b want 1", in_ready); end
    advance();
    in_valid = 1'b0; msk = 8'h01;
    #1;
    checks++; if (msk_ready !== 1'b0) begin errors++; $display("FAIL zero_cnt_occ got %b want 0", msk_ready); end
    idle();
    advance();
  endtask

  task automatic test_rst_mid();
    idle();
    in_valid = 1'b1; in_cnt = 4'd6; in_w = rand_beat();
    advance();
    in_valid = 1'b0;
    msk_valid = 1'b1; msk = 8'h00;
    advance();
    msk_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    advance();
    rst = 1'b0;
    idle();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", out_valid); end
    checks++; if (out_vld !== 8'h00) begin errors++; $display("FAIL mid_vld got %h want 00", out_vld); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
    msk = 8'h01;
    #1;
    checks++; if (msk_ready !== 1'b0) begin errors++; $display("FAIL mid_occ got %b want 0", msk_ready); end
    idle();
    advance();
  endtask

  task automatic test_random();
    for (int it = 0; it < 600; it++) begin
      in_valid  = 1'($urandom % 2);
      in_cnt    = 4'($urandom_range(N, 0));
      in_w      = rand_beat();
      msk_valid = 1'($urandom % 2);
      msk       = ($urandom % 3 == 0) ? N'($urandom) : N'($urandom & $urandom);
      out_ready = ($urandom % 4) != 0;
      #1;
      checks++; if (in_ready !== exp_in_rdy()) begin errors++; $display("FAIL rnd_in_ready it %0d got %b want %b", it, in_ready, exp_in_rdy()); end
      checks++; if (msk_ready !== exp_msk_rdy()) begin errors++; $display("FAIL rnd_msk_ready it %0d got %b want %b", it, msk_ready, exp_msk_rdy()); end
      advance();
      checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rnd_valid it %0d got %b want %b", it, out_valid, m_ov); end
      if (m_ov) begin
        checks++; if (out_vld !== m_vld) begin errors++; $display("FAIL rnd_vld it %0d got %h want %h", it, out_vld, m_vld); end
        checks++; if (out_w !== m_w) begin errors++; $display("FAIL rnd_w it %0d got %h want %h", it, out_w, m_w); end
      end
    end
    idle();
    advance();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    m_ov = 1'b0; m_vld = '0; m_w = '0;
    test_reset();
    test_example();
    test_wait_mask();
    test_full_hold();
    test_overfill();
    test_zero();
    test_random();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unpack.md
UNPACK -- requirements
Module: unpack

Interface
REQ-001 SHALL have parameter N, default 8: lane count.
REQ-002 SHALL have parameter W, default 32: lane data width in bits.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: packed beat present.
REQ-006 SHALL have port in_ready, output, 1: packed beat accepted when in_valid & in_ready.
REQ-007 SHALL have port in_w, input, N x W: packed data; lanes 0..in_cnt-1 meaningful.
REQ-008 SHALL have port in_cnt, input, clog2(N)+1: count of valid packed lanes, 0..N.
REQ-009 SHALL have port msk_valid, input, 1: scatter mask present.
REQ-010 SHALL have port msk_ready, output, 1: mask accepted when msk_valid & msk_ready.
REQ-011 SHALL have port msk, input, N: destination lanes of the output beat.
REQ-012 SHALL have port out_valid, output, 1: registered output beat present.
REQ-013 SHALL have port out_ready, input, 1: output beat consumed when out_valid & out_ready.
REQ-014 SHALL have port out_w, output, N x W: scattered data, registered.
REQ-015 SHALL have port out_vld, output, N: registered per-lane valid, equal to accepted msk.

Function
REQ-016 SHALL hold an in-order residue buffer of 2N entries of W bits plus occupancy count occ (0..2N, registered).
REQ-017 SHALL drive in_ready = (occ <= N), using registered occ only.
REQ-018 SHALL drive msk_ready = (occ >= popcnt(msk)) & (~out_valid | out_ready).
REQ-019 On mask accept, SHALL take the oldest popcnt(msk) buffer entries and place the k-th oldest into the k-th lowest set bit of msk.
REQ-020 On mask accept, SHALL load out_w/out_vld at the next edge: out_vld = msk, out_w lanes with msk=0 driven to zero, out_valid = 1; latency one cycle.
REQ-021 SHALL hold out_w/out_vld/out_valid stable while out_valid & ~out_ready.
REQ-022 SHALL clear out_valid on out_ready when no mask is accepted in the same cycle; if one is accepted, the new beat replaces the old with out_valid remaining 1.
REQ-023 On input accept, SHALL append in_w lanes 0..in_cnt-1 after the entries remaining following any same-cycle consumption, preserving lane order.
REQ-024 SHALL update occ_next = occ - (mask accepted ? popcnt(msk) : 0) + (input accepted ? in_cnt : 0); data from an input accepted in cycle t is first usable by a mask at cycle t+1.
REQ-025 SHALL treat msk = 0 as legal: it produces an output beat with out_vld = 0 and consumes nothing.
REQ-026 SHALL treat in_cnt = 0 as legal: the beat is accepted with no buffer change.
REQ-027 SHALL treat in_cnt > N as illegal; the behaviour is undefined and a simulation assertion SHALL fire.
REQ-028 SHALL never overflow: occ <= N at input accept and in_cnt <= N, so occ never exceeds 2N.

Reset
REQ-029 On rst, SHALL set occ = 0, out_valid = 0, out_vld = 0; in_ready = 1 and msk_ready = 1 in the following cycle.
REQ-030 SHALL leave out_w and buffer data unreset; out_w is don't-care while out_valid = 0.
REQ-031 SHALL give rst priority over all handshakes; beats presented during rst are not accepted.

Configuration
REQ-032 SHALL support macro UNPACK_FLUSH_EN; when defined, it adds input flush (1 bit).
REQ-033 With UNPACK_FLUSH_EN, flush = 1 SHALL set occ = 0 next cycle and force in_ready = 0 and msk_ready = 0 that cycle; the output register is unaffected.
REQ-034 Without UNPACK_FLUSH_EN, the flush port SHALL be absent and residue is discarded only by rst.

Verification
REQ-035 N=8: input in_cnt=3 {A,B,C}, then msk=8'b1010_0100 -> one cycle later out_vld=8'hA4, lane2=A, lane5=B, lane7=C, other lanes 0, occ=0.
REQ-036 Input in_cnt=2 {A,B}, msk=8'h07 pending -> msk_ready=0 until input {C} (in_cnt=1) lands; then lanes0..2 = A,B,C.
REQ-037 occ=8, out_ready=0 with out_valid=1 -> in_ready=1 and msk_ready=0, out_* held; out_ready=1 plus msk=8'hFF in the same cycle -> new beat next cycle, occ=0.
REQ-038 occ=9 -> in_ready=0; mask popcnt 4 accepted -> occ=5 and in_ready=1 next cycle; input in_cnt=8 -> occ=13.
REQ-039 msk=0 with occ=0 -> out_valid=1, out_vld=0, occ unchanged; in_cnt=0 beat -> accepted, occ unchanged.
REQ-040 rst asserted mid-stream with occ=6 and out_valid=1 -> next cycle occ=0, out_valid=0, out_vld=0; with UNPACK_FLUSH_EN, flush gives occ=0 while the output beat is retained.
